// File: rtl/bus_uart_fifo.sv
// CPU-bus bridge to uart_rx/uart_tx: synchronised strobes, RX/TX FIFOs, HSK/DAT/STAT/CTRL registers and IRQ.
// Read data and d_oe are registered three sys_clk after the strobe; pops and pushes occur on the strobe's trailing edge.
module bus_uart_fifo #(
  parameter logic [15:0] BASE_ADDR = 16'h0FF0,
  parameter int          RX_DEPTH  = 16,
  parameter int          TX_DEPTH  = 16,
  parameter logic [7:0]  EH_REQ    = 8'hCC,
  parameter logic [7:0]  EH_ACK    = 8'h33
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic        NRDS,
  input  logic        NWDS,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_ready,
  output logic        rx_clear,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int RXW = $clog2(RX_DEPTH);
  localparam int TXW = $clog2(TX_DEPTH);
  localparam logic [RXW:0] RX_FULL = (RXW+1)'(RX_DEPTH);
  localparam logic [TXW:0] TX_FULL = (TXW+1)'(TX_DEPTH);

  typedef enum logic       {R_IDLE, R_CLR} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT} tx_state_t;

  logic [15:0] a_s1_q, a_s2_q;
  logic [7:0]  d_s1_q, d_s2_q;
  logic        nrds_s1_q, nrds_s2_q, nwds_s1_q, nwds_s2_q;
  logic [1:0]  fill_q;
  logic        rd_hi_q, rd_armed_q, wr_hi_q, wr_armed_q;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      a_s1_q <= '0; a_s2_q <= '0; d_s1_q <= '0; d_s2_q <= '0;
      nrds_s1_q <= 1'b1; nrds_s2_q <= 1'b1; nwds_s1_q <= 1'b1; nwds_s2_q <= 1'b1;
      fill_q <= '0;
    end else begin
      a_s1_q <= A;       a_s2_q <= a_s1_q;
      d_s1_q <= d_in;    d_s2_q <= d_s1_q;
      nrds_s1_q <= NRDS; nrds_s2_q <= nrds_s1_q;
      nwds_s1_q <= NWDS; nwds_s2_q <= nwds_s1_q;
      fill_q <= {fill_q[0], 1'b1};
    end
  end

  logic       sync_ok, hit, rd_done, wr_done;
  logic [2:0] off;
  assign sync_ok = fill_q[1];
  assign hit     = (a_s2_q[15:3] == BASE_ADDR[15:3]);
  assign off     = a_s2_q[2:0];
  assign rd_done = sync_ok & nrds_s2_q & rd_armed_q & hit;
  assign wr_done = sync_ok & nwds_s2_q & wr_armed_q & hit;

  // An access only counts if its falling edge was seen after a genuine high, so an
  // access already in progress when reset drops never completes a pop or push.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rd_hi_q <= 1'b0; rd_armed_q <= 1'b0; wr_hi_q <= 1'b0; wr_armed_q <= 1'b0;
    end else if (sync_ok) begin
      if (nrds_s2_q)    begin rd_hi_q <= 1'b1; rd_armed_q <= 1'b0; end
      else if (rd_hi_q) begin rd_hi_q <= 1'b0; rd_armed_q <= 1'b1; end
      if (nwds_s2_q)    begin wr_hi_q <= 1'b1; wr_armed_q <= 1'b0; end
      else if (wr_hi_q) begin wr_hi_q <= 1'b0; wr_armed_q <= 1'b1; end
    end
  end

  rx_state_t   rx_state_q;
  tx_state_t   tx_state_q;
  logic [RXW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [TXW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [RXW:0]   rx_cnt_q, rx_cnt_d;
  logic [TXW:0]   tx_cnt_q, tx_cnt_d;
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [7:0]     tx_mem [TX_DEPTH];
  logic           rx_ovr_q, tx_ovf_q, rx_ie_q, tx_ie_q;
  logic           rx_clear_q, tx_send_q, d_oe_q, irq_q;
  logic [7:0]     tx_data_q, d_out_q;

  logic rx_nempty, rx_full, tx_nempty, tx_full, tx_idle;
  logic flush, ctrl_wr, stat_rd, rx_pop, rx_take, rx_push, rx_lost;
  logic tx_wr, tx_start, tx_push, tx_drop;
  logic [7:0] rx_head, tx_head, stat, rd_mux;

  assign rx_nempty = (rx_cnt_q != '0);
  assign rx_full   = (rx_cnt_q == RX_FULL);
  assign tx_nempty = (tx_cnt_q != '0);
  assign tx_full   = (tx_cnt_q == TX_FULL);
  assign tx_idle   = ~tx_nempty & tx_ready & ~tx_send_q;
  assign rx_head   = rx_mem[rx_rd_ptr_q];
  assign tx_head   = tx_mem[tx_rd_ptr_q];

  assign flush    = wr_done & (off == 3'd6) & d_s2_q[7];
  assign ctrl_wr  = wr_done & (off == 3'd6);
  assign stat_rd  = rd_done & (off == 3'd5);
  assign rx_pop   = rd_done & (off == 3'd4) & rx_nempty;
  assign rx_take  = (rx_state_q == R_IDLE) & rx_data_ready;
  assign rx_push  = rx_take & ~flush & (~rx_full | rx_pop);
  assign rx_lost  = rx_take & rx_full & ~rx_pop;
  assign tx_wr    = wr_done & (off == 3'd4);
  assign tx_start = (tx_state_q == T_IDLE) & tx_nempty & tx_ready & ~flush;
  assign tx_push  = tx_wr & (~tx_full | tx_start);
  assign tx_drop  = tx_wr & tx_full & ~tx_start;
  assign stat     = {3'b000, tx_ovf_q, rx_ovr_q, tx_idle, ~tx_full, rx_nempty};

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    tx_cnt_d = tx_cnt_q;
    if (rx_push & ~rx_pop)      rx_cnt_d = rx_cnt_q + (RXW+1)'(1);
    else if (~rx_push & rx_pop) rx_cnt_d = rx_cnt_q - (RXW+1)'(1);
    if (tx_push & ~tx_start)      tx_cnt_d = tx_cnt_q + (TXW+1)'(1);
    else if (~tx_push & tx_start) tx_cnt_d = tx_cnt_q - (TXW+1)'(1);
  end

  always_comb begin
    rd_mux = 8'h00;
    case (off)
      3'd1: rd_mux = rx_nempty ? EH_ACK : EH_REQ;
      3'd4: rd_mux = rx_nempty ? rx_head : 8'h00;
      3'd5: rd_mux = stat;
      3'd6: rd_mux = {6'b0, tx_ie_q, rx_ie_q};
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_data;
    if (tx_push) tx_mem[tx_wr_ptr_q] <= d_s2_q;
  end

  always_ff @(posedge sys_clk) begin
    if (reset || flush) begin
      rx_wr_ptr_q <= '0; rx_rd_ptr_q <= '0; rx_cnt_q <= '0;
      tx_wr_ptr_q <= '0; tx_rd_ptr_q <= '0; tx_cnt_q <= '0;
    end else begin
      if (rx_push)  rx_wr_ptr_q <= rx_wr_ptr_q + RXW'(1);
      if (rx_pop)   rx_rd_ptr_q <= rx_rd_ptr_q + RXW'(1);
      if (tx_push)  tx_wr_ptr_q <= tx_wr_ptr_q + TXW'(1);
      if (tx_start) tx_rd_ptr_q <= tx_rd_ptr_q + TXW'(1);
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      d_oe_q <= 1'b0; d_out_q <= 8'h00; irq_q <= 1'b0;
      rx_ie_q <= 1'b0; tx_ie_q <= 1'b0; rx_ovr_q <= 1'b0; tx_ovf_q <= 1'b0;
    end else begin
      d_oe_q  <= hit & ~nrds_s2_q;
      d_out_q <= (hit & ~nrds_s2_q) ? rd_mux : 8'h00;
      irq_q   <= (rx_ie_q & rx_nempty) | (tx_ie_q & tx_idle);
      if (ctrl_wr) {tx_ie_q, rx_ie_q} <= d_s2_q[1:0];
      if (flush) begin
        rx_ovr_q <= 1'b0; tx_ovf_q <= 1'b0;
      end else begin
        // A fresh overflow in the same cycle as a STAT read stays visible.
        if (stat_rd) begin rx_ovr_q <= 1'b0; tx_ovf_q <= 1'b0; end
        if (rx_lost) rx_ovr_q <= 1'b1;
        if (tx_drop) tx_ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      rx_state_q <= R_IDLE; rx_clear_q <= 1'b0;
    end else begin
      case (rx_state_q)
        R_IDLE: if (rx_data_ready) begin rx_state_q <= R_CLR; rx_clear_q <= 1'b1; end
        R_CLR:  if (!rx_data_ready) begin rx_state_q <= R_IDLE; rx_clear_q <= 1'b0; end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      tx_state_q <= T_IDLE; tx_send_q <= 1'b0; tx_data_q <= 8'h00;
    end else begin
      case (tx_state_q)
        T_IDLE: if (tx_start) begin tx_data_q <= tx_head; tx_send_q <= 1'b1; tx_state_q <= T_SEND; end
        T_SEND: if (!tx_ready) begin tx_send_q <= 1'b0; tx_state_q <= T_WAIT; end
        T_WAIT: if (tx_ready) tx_state_q <= T_IDLE;
        default: begin tx_state_q <= T_IDLE; tx_send_q <= 1'b0; end
      endcase
    end
  end

  assign d_out    = d_out_q;
  assign d_oe     = d_oe_q;
  assign rx_clear = rx_clear_q;
  assign tx_data  = tx_data_q;
  assign tx_send  = tx_send_q;
  assign irq      = irq_q;

endmodule
